alu_issue_decoder: RTL and testbench
====================================

Name: alu_issue_decoder

Overview:
- Decode/issue stage that drives the ALU operation interface: `opcode[5:0]`, `operand_0[31:0]`, `operand_1[31:0]`.
- Accepts an RV32I instruction word plus already-read register values through a valid/ready handshake.
- Decodes R-type (0110011) and I-type ALU (0010011) instructions into the ALU opcode encoding and operand pair, plus destination/write-enable.
- Holds the result in a single registered output stage with backpressure, sitting between register-file read and the ALU.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  instruction/operands present.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  RV32I instruction word.
- rs1_data  input  32  value of register rs1.
- rs2_data  input  32  value of register rs2.
- out_valid  output  1  decoded operation held in the output register.
- out_ready  input  1  downstream accepts the held operation.
- opcode  output  6  ALU opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=6, SRL=7, SRA=8.
- operand_0  output  32  ALU operand 0.
- operand_1  output  32  ALU operand 1.
- rd  output  5  destination register index (`instr[11:7]`).
- rd_we  output  1  write-back enable.
- illegal  output  1  held instruction is not a supported ALU op.
- illegal_count  output  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (`rst_n` low at a clk edge): `out_valid`, `opcode`, `operand_0`, `operand_1`, `rd`, `rd_we`, `illegal` and `illegal_count` all cleared to 0. Reset mid-transaction discards the held operation.
- Handshake:
  - `in_ready = !out_valid || out_ready` (combinational).
  - Accept when `in_valid && in_ready`: the output register loads the decode and `out_valid=1` next cycle.
  - If `out_valid && out_ready` with no accept, `out_valid` goes to 0.
  - Accept and drain in the same cycle gives back-to-back throughput of 1 op/cycle.
- Latency: exactly 1 cycle from accept to `out_valid`.
- While `out_valid && !out_ready`, all outputs are held stable and `in_ready=0`.
- `rs1_data`/`rs2_data` are sampled only at accept.
- R-type, funct7=0000000: funct3 000→ADD, 001→SLL, 100→XOR, 101→SRL, 110→OR, 111→AND.
- R-type, funct7=0100000: funct3 000→SUB, 101→SRA.
- R-type operands: `operand_0=rs1_data`, `operand_1=rs2_data`.
- I-type: funct3 000→ADD, 100→XOR, 110→OR, 111→AND.
  - `operand_1` = `instr[31:20]` sign-extended to 32 bits.
- I-type shifts: funct3 001 with `instr[31:25]=0000000`→SLL; funct3 101 with `instr[31:25]=0000000`→SRL; funct3 101 with `instr[31:25]=0100000`→SRA.
  - `operand_1` = {27'b0, `instr[24:20]`}.
- I-type operand 0: `operand_0=rs1_data`.
- Illegal: any other opcode/funct3/funct7 combination (SLT, SLTU, SLTI, SLTIU, loads, branches, ...).
  - Still accepted and handshaken.
  - Outputs `opcode=0`, `operands=0`, `illegal=1`, `rd_we=0`.
- `rd_we = !illegal && rd!=0` (writes to x0 suppressed). `rd` is always `instr[11:7]`.
- `illegal_count`: +1 on each accepted illegal instruction; saturates at all-ones with no wrap.

Test Plan:
- Reset: hold `rst_n=0` 2 cycles with `in_valid=1` → `out_valid=0`, `illegal_count=0`, `in_ready=1` after release.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, `out_ready=1` → next cycle `opcode=0`, `operand_0=5`, `operand_1=7`, `rd=3`, `rd_we=1`.
- ADDI x1,x0,-1 (0xFFF00093), rs1=0 → `opcode=0`, `operand_1=0xFFFFFFFF`; SRAI x5,x6,4 (0x40435293) → `opcode=8`, `operand_1=4`.
- Backpressure: `out_ready=0` for 3 cycles with a new `in_valid` → `in_ready=0`, outputs frozen; `out_ready=1` → held op drains and new op appears next cycle; a stream of 4 ops with `out_ready=1` yields 4 consecutive `out_valid` cycles.
- Illegal: SLT (0x0020A1B3) → `illegal=1`, `opcode=0`, `rd_we=0`, `illegal_count` increments; with CNT_W=2, 5 illegal ops → count stays 3.
- Write to x0: ADD x0,x1,x2 → `rd_we=0`, `illegal=0`; reset asserted while `out_valid=1` → `out_valid=0` next edge.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// RV32I ALU decode/issue stage: decodes R-type and I-type ALU instructions
// into an ALU opcode and operand pair behind a single registered output
// stage with a valid/ready handshake. Unsupported encodings still flow
// through the pipe, flagged as illegal, and are counted.
module alu_issue_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       opcode,
  output logic [31:0]      operand_0,
  output logic [31:0]      operand_1,
  output logic [4:0]       rd,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd6;
  localparam logic [5:0] OP_SRL = 6'd7;
  localparam logic [5:0] OP_SRA = 6'd8;

  localparam logic [6:0] MAJ_OP    = 7'b0110011;
  localparam logic [6:0] MAJ_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]  maj;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] shamt;

  logic [5:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_ill;
  logic        accept;

  logic             out_valid_q, out_valid_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [31:0]      operand_0_q, operand_0_d;
  logic [31:0]      operand_1_q, operand_1_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign maj   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign shamt = {27'b0, instr[24:20]};

  // Instruction decode; anything unmatched stays illegal with zero operands.
  always_comb begin
    dec_op  = OP_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_ill = 1'b1;
    if (maj == MAJ_OP) begin
      dec_ill = 1'b0;
      unique case ({f7, f3})
        {F7_BASE, 3'b000}: dec_op = OP_ADD;
        {F7_BASE, 3'b001}: dec_op = OP_SLL;
        {F7_BASE, 3'b100}: dec_op = OP_XOR;
        {F7_BASE, 3'b101}: dec_op = OP_SRL;
        {F7_BASE, 3'b110}: dec_op = OP_OR;
        {F7_BASE, 3'b111}: dec_op = OP_AND;
        {F7_ALT,  3'b000}: dec_op = OP_SUB;
        {F7_ALT,  3'b101}: dec_op = OP_SRA;
        default:           dec_ill = 1'b1;
      endcase
      if (!dec_ill) begin
        dec_a = rs1_data;
        dec_b = rs2_data;
      end
    end else if (maj == MAJ_OPIMM) begin
      dec_ill = 1'b0;
      dec_b   = imm_i;
      unique case (f3)
        3'b000: dec_op = OP_ADD;
        3'b100: dec_op = OP_XOR;
        3'b110: dec_op = OP_OR;
        3'b111: dec_op = OP_AND;
        3'b001: begin
          dec_op  = OP_SLL;
          dec_b   = shamt;
          dec_ill = (f7 != F7_BASE);
        end
        3'b101: begin
          dec_op  = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
          dec_b   = shamt;
          dec_ill = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
        default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
        dec_op = OP_ADD;
        dec_b  = '0;
      end else begin
        dec_a = rs1_data;
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register next-state: load on accept, drop valid on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    operand_0_d = operand_0_q;
    operand_1_d = operand_1_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = dec_op;
      operand_0_d = dec_a;
      operand_1_d = dec_b;
      rd_d        = instr[11:7];
      rd_we_d     = !dec_ill && (instr[11:7] != 5'd0);
      illegal_d   = dec_ill;
      if (dec_ill && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      operand_0_q <= '0;
      operand_1_q <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      operand_0_q <= operand_0_d;
      operand_1_q <= operand_1_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign opcode        = opcode_q;
  assign operand_0     = operand_0_q;
  assign operand_1     = operand_1_q;
  assign rd            = rd_q;
  assign rd_we         = rd_we_q;
  assign illegal       = illegal_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: expected decodes are queued at
// accept and checked while held, so a stalled op is re-checked every cycle.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, rd_we, illegal;
  logic [5:0]  opcode;
  logic [31:0] operand_0, operand_1;
  logic [4:0]  rd;
  logic [15:0] illegal_count;

  logic        s_in_ready, s_out_valid, s_rd_we, s_illegal;
  logic [5:0]  s_opcode;
  logic [31:0] s_operand_0, s_operand_1;
  logic [4:0]  s_rd;
  logic [1:0]  s_illegal_count;

  always #5 clk = ~clk;

  alu_issue_decoder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .operand_0(operand_0), .operand_1(operand_1), .rd(rd), .rd_we(rd_we),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  // Narrow counter instance, shares stimulus, used to check saturation.
  alu_issue_decoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .opcode(s_opcode),
    .operand_0(s_operand_0), .operand_1(s_operand_1), .rd(s_rd), .rd_we(s_rd_we),
    .illegal(s_illegal), .illegal_count(s_illegal_count)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt16 = 0;
  int   cnt2  = 0;
  bit   after_rst = 1'b1;
  int   ov_run = 0;
  int   ov_max = 0;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'b0010011};
  endfunction

  // Reference decode straight from the ISA table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [6:0] m, f7;
    logic [2:0] f3;
    logic ok;
    m = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; ok = 1'b1;
    if (m == 7'h33) begin
      e.a = a; e.b = b;
      if      (f7 == 7'h00 && f3 == 3'd0) e.op = 6'd0;
      else if (f7 == 7'h00 && f3 == 3'd1) e.op = 6'd6;
      else if (f7 == 7'h00 && f3 == 3'd4) e.op = 6'd4;
      else if (f7 == 7'h00 && f3 == 3'd5) e.op = 6'd7;
      else if (f7 == 7'h00 && f3 == 3'd6) e.op = 6'd3;
      else if (f7 == 7'h00 && f3 == 3'd7) e.op = 6'd2;
      else if (f7 == 7'h20 && f3 == 3'd0) e.op = 6'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) e.op = 6'd8;
      else ok = 1'b0;
    end else if (m == 7'h13) begin
      e.a = a;
      e.b = {{20{ins[31]}}, ins[31:20]};
      if      (f3 == 3'd0) e.op = 6'd0;
      else if (f3 == 3'd4) e.op = 6'd4;
      else if (f3 == 3'd6) e.op = 6'd3;
      else if (f3 == 3'd7) e.op = 6'd2;
      else if (f3 == 3'd1 && f7 == 7'h00) begin e.op = 6'd6; e.b = {27'b0, ins[24:20]}; end
      else if (f3 == 3'd5 && f7 == 7'h00) begin e.op = 6'd7; e.b = {27'b0, ins[24:20]}; end
      else if (f3 == 3'd5 && f7 == 7'h20) begin e.op = 6'd8; e.b = {27'b0, ins[24:20]}; end
      else ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin e.op = '0; e.a = '0; e.b = '0; end
    e.ill = !ok;
    e.rd  = ins[11:7];
    e.we  = ok && (ins[11:7] != 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check state a little later, update model.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    bit rdy;
    exp_t e;
    @(negedge clk);
    rst_n = !rst; in_valid = v; instr = ins; rs1_data = a; rs2_data = b; out_ready = ordy;
    #2;
    if (after_rst) begin
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_operand_0", operand_0, 32'd0);
      chk("rst_operand_1", operand_1, 32'd0);
      chk("rst_rd_we_ill", {30'd0, rd_we, illegal}, 32'd0);
      after_rst = 1'b0;
    end
    rdy = (q.size() == 0) || ordy;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("illegal_count", 32'(illegal_count), 32'(cnt16));
    chk("illegal_count_sat", 32'(s_illegal_count), 32'(cnt2));
    if (out_valid) ov_run++; else ov_run = 0;
    if (ov_run > ov_max) ov_max = ov_run;
    if (q.size() != 0) begin
      chk("opcode", 32'(opcode), 32'(q[0].op));
      chk("operand_0", operand_0, q[0].a);
      chk("operand_1", operand_1, q[0].b);
      chk("rd", 32'(rd), 32'(q[0].rd));
      chk("rd_we", 32'(rd_we), 32'(q[0].we));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    if (rst) begin
      q.delete(); cnt16 = 0; cnt2 = 0; after_rst = 1'b1;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (v && rdy) begin
        e = model(ins, a, b);
        q.push_back(e);
        if (e.ill) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt2 < 3) cnt2++;
        end
      end
    end
  endtask

  logic [31:0] tbl [10];

  initial begin
    tbl[0] = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    tbl[1] = rtype(7'h20, 5'd4, 5'd5, 3'd0, 5'd6);
    tbl[2] = rtype(7'h00, 5'd7, 5'd8, 3'd1, 5'd9);
    tbl[3] = rtype(7'h20, 5'd7, 5'd8, 3'd5, 5'd10);
    tbl[4] = itype(12'h800, 5'd1, 3'd0, 5'd11);
    tbl[5] = itype(12'h0F0, 5'd1, 3'd6, 5'd12);
    tbl[6] = itype(12'h01F, 5'd1, 3'd5, 5'd13);
    tbl[7] = 32'h0020A1B3;
    tbl[8] = 32'h123450B7;
    tbl[9] = itype(12'h403, 5'd1, 3'd1, 5'd14);

    // Reset held with in_valid high, then idle.
    cycle(1, 1, 32'h002081B3, 5, 7, 1);
    cycle(1, 1, 32'h002081B3, 5, 7, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // ADD x3,x1,x2 ; ADDI x1,x0,-1 ; SRAI x5,x6,4
    cycle(0, 1, 32'h002081B3, 5, 7, 1);
    cycle(0, 1, 32'hFFF00093, 0, 32'hDEAD, 1);
    cycle(0, 1, 32'h40435293, 32'h80000000, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Backpressure: held op frozen for 3 cycles while a new op waits.
    cycle(0, 1, itype(12'h0FF, 5'd2, 3'd7, 5'd4), 32'hA5A5_F00F, 0, 1);
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd7), 32'h1111, 32'h2222, 0);
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd7), 32'h3333, 32'h4444, 0);
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd7), 32'h5555, 32'h6666, 0);
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd7), 32'h7777, 32'h8888, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Four back-to-back ops.
    ov_max = 0;
    cycle(0, 1, tbl[1], 100, 30, 1);
    cycle(0, 1, tbl[2], 1, 5, 1);
    cycle(0, 1, itype(12'h005, 5'd3, 3'd1, 5'd8), 32'hF, 0, 1);
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'hF0, 32'h0F, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("b2b_run", 32'(ov_max), 32'd4);

    // Illegal ops: SLT, LW, SLTI, BEQ, R-type bad funct7.
    cycle(0, 1, 32'h0020A1B3, 9, 9, 1);
    cycle(0, 1, 32'h0000A103, 9, 9, 1);
    cycle(0, 1, itype(12'h005, 5'd1, 3'd2, 5'd3), 9, 9, 1);
    cycle(0, 1, 32'h00208463, 9, 9, 1);
    cycle(0, 1, rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd3), 9, 9, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Write to x0 suppressed.
    cycle(0, 1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 4, 6, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Random mix with random backpressure.
    for (int i = 0; i < 40; i++)
      cycle(0, 1'($urandom_range(0, 1)), tbl[$urandom_range(0, 9)], $urandom, $urandom,
            1'($urandom_range(0, 1)));
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Reset while an op is held.
    cycle(0, 1, tbl[0], 1, 2, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
